// File: rtl/sram_ctrl_pkg.sv
// Shared types and default widths for the SRAM request controller.
package sram_ctrl_pkg;

  localparam int SRAM_DATA_W = 8;
  localparam int SRAM_ADDR_W = 4;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPT, VRFY, VCAPT, RESP} sram_ctrl_state_e;

endpackage

// File: rtl/sram_req_ctrl.sv
// SRAM request controller: takes one valid/ready request at a time, drives the
// registered pins of a single-port read-first SRAM and returns one response.
// Optional build macro SRAM_CTRL_VERIFY_EN adds a read-back check after writes
// (VRFY/VCAPT states) that reports a mismatch on rsp_err.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// ISSUE | SRAM samples addr/we/din at the end of this cycle
// CAPT  | sram_dout holds the pre-write / read data; captured into rsp_rdata
// VRFY  | write verify: SRAM re-reads the same address with we low
// VCAPT | write verify: compare re-read data against the written data
// RESP  | response presented until rsp_ready
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_W,
  parameter int ADDR_WIDTH = SRAM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  sram_ctrl_state_e state, next_state;
  logic             accept;

  assign accept = req_valid && req_ready;

`ifdef SRAM_CTRL_VERIFY_EN
  // remembers the request direction so CAPT knows whether to run the verify pass
  logic we_q;
`endif

  // next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = ISSUE;
      ISSUE: next_state = CAPT;
`ifdef SRAM_CTRL_VERIFY_EN
      CAPT:  next_state = we_q ? VRFY : RESP;
      VRFY:  next_state = VCAPT;
      VCAPT: next_state = RESP;
`else
      CAPT:  next_state = RESP;
`endif
      RESP:  if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // state register plus handshake flags derived from the next state so they are flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == IDLE);
      rsp_valid <= (next_state == RESP);
    end
  end

  // SRAM pin registers; we is only ever high for the single ISSUE cycle after accept.
  // sram_din doubles as the held write data for the verify compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_we   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      sram_we <= accept && req_we;
      if (accept) begin
        sram_addr <= req_addr;
        sram_din  <= req_wdata;
      end
    end
  end

  // response data: read data, or pre-write content for writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
    end else if (state == CAPT) begin
      rsp_rdata <= sram_dout;
    end
  end

`ifdef SRAM_CTRL_VERIFY_EN
  // verify result: cleared on every accept, set from the read-back compare in VCAPT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      if (accept) begin
        rsp_err <= 1'b0;
        we_q    <= req_we;
      end else if (state == VCAPT) begin
        rsp_err <= (sram_dout != sram_din);
      end
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: read-first SRAM model plus a transaction-level
// reference memory; directed cases and randomized traffic.
module tb_sram_req_ctrl;

  logic       clk, rst_n;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic       sram_we;
  logic [3:0] sram_addr;
  logic [7:0] sram_din, sram_dout;

  int tests  = 0;
  int failed = 0;

`ifdef SRAM_CTRL_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  sram_req_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // content actually stored by the macro; in the verify build address 2 has bit0 stuck at 0
  function automatic logic [7:0] stored(input logic [7:0] d, input logic [3:0] a);
    if (VERIFY && a == 4'd2) return d & 8'hFE;
    return d;
  endfunction

  // read-first synchronous SRAM macro model
  logic [7:0] sram_mem [16];
  always @(posedge clk) begin
    sram_dout <= sram_mem[sram_addr];
    if (sram_we) sram_mem[sram_addr] = stored(sram_din, sram_addr);
  end

  // reference memory tracked per transaction
  logic [7:0] ref_mem [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // one request/response; entered and left at a negedge
  task automatic do_req(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                        input int hold, output logic [7:0] got, output logic got_err);
    int lat, we_cycles, waited;
    logic [7:0] exp_rdata;
    logic exp_err;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", req_ready, 1);
      got = 8'h00;
      got_err = 1'b0;
      return;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    exp_rdata = ref_mem[addr];
    exp_err   = 1'b0;
    if (we) begin
      ref_mem[addr] = stored(wd, addr);
      exp_err = VERIFY && (stored(wd, addr) != wd);
    end
    lat = (we && VERIFY) ? 5 : 3;
    we_cycles = 0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 4'($urandom);
        req_wdata = 8'($urandom);
        check("issue_addr", sram_addr, addr);
        if (we) check("issue_din", sram_din, wd);
      end
      if (sram_we) we_cycles++;
      check("rsp_valid_timing", rsp_valid, (k == lat));
      check("req_ready_busy", req_ready, 0);
    end
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", rsp_err, exp_err);
    check("sram_we_cycles", we_cycles, we ? 1 : 0);
    got = rsp_rdata;
    got_err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("held_valid", rsp_valid, 1);
      check("held_rdata", rsp_rdata, exp_rdata);
      check("held_err", rsp_err, exp_err);
      check("held_req_ready", req_ready, 0);
      check("held_sram_we", sram_we, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_consumed", rsp_valid, 0);
    check("req_ready_after_rsp", req_ready, 1);
  endtask

  logic [7:0] got;
  logic       got_err;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      sram_mem[i] = 8'(8'h20 + i * 7);
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[0] = 8'h11;
    ref_mem[0]  = 8'h11;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_din", sram_din, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", req_ready, 1);

    // 1: write a=3 0xAA then 0x55; second returns old 0xAA
    do_req(1'b1, 4'd3, 8'hAA, 0, got, got_err);
    do_req(1'b1, 4'd3, 8'h55, 0, got, got_err);
    check("t1_old_data", got, 8'hAA);
    // 2: read back
    do_req(1'b0, 4'd3, 8'h00, 0, got, got_err);
    check("t2_read", got, 8'h55);
    // 3: response held 5 cycles
    do_req(1'b0, 4'd3, 8'h00, 5, got, got_err);
    check("t3_held_read", got, 8'h55);
    // 4: address extremes
    do_req(1'b1, 4'd15, 8'hC3, 1, got, got_err);
    do_req(1'b0, 4'd0, 8'h00, 0, got, got_err);
    check("t4_addr0", got, 8'h11);
    do_req(1'b0, 4'd15, 8'h00, 0, got, got_err);
    check("t4_addr15", got, 8'hC3);

    // 5: reset during ISSUE of a write
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 8'h77;
    @(negedge clk);
    req_valid = 1'b0;
    check("t5_we_in_issue", sram_we, 1);
    rst_n = 1'b0;
    #1;
    check("t5_we_async_low", sram_we, 0);
    check("t5_no_rsp", rsp_valid, 0);
    check("t5_ready_in_rst", req_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_no_rsp_after", rsp_valid, 0);
    @(negedge clk);
    check("t5_ready_after", req_ready, 1);
    check("t5_no_rsp_late", rsp_valid, 0);
    do_req(1'b0, 4'd5, 8'h00, 0, got, got_err);
    check("t5_not_written", got, 8'h43);

`ifdef SRAM_CTRL_VERIFY_EN
    // 6: stuck bit at address 2
    do_req(1'b1, 4'd2, 8'h01, 0, got, got_err);
    check("t6_err_set", got_err, 1);
    do_req(1'b1, 4'd2, 8'h02, 0, got, got_err);
    check("t6_err_clear", got_err, 0);
    check("t6_old_data", got, 8'h00);
`endif

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      do_req(1'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, 3)), got, got_err);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
